// File: rtl/color_freq_counter.sv
// Colour-sensor front end: steps the filter through red, green, blue and clear,
// counts sensor pulses over a fixed gate window per filter, publishes all four at once.
module color_freq_counter #(
    parameter int GATE_CYCLES   = 100000,
    parameter int SETTLE_CYCLES = 10000,
    parameter int CNT_W         = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sensor_out,
    input  logic             start,
    output logic             s2,
    output logic             s3,
    output logic             busy,
    output logic [CNT_W-1:0] red_freq,
    output logic [CNT_W-1:0] green_freq,
    output logic [CNT_W-1:0] blue_freq,
    output logic [CNT_W-1:0] clear_freq,
    output logic             done
);

    // state  | meaning
    // IDLE   | waiting for start high
    // SETTLE | filter lines just changed, letting the sensor output settle
    // GATE   | counting rise pulses for the current filter
    // STORE  | latch the count into the channel shadow, advance or publish
    // DONE   | results valid; waiting for start low
    typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, DONE} state_t;

    localparam int TMR_MAX = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);
    localparam logic [TMR_W-1:0] SETTLE_LOAD = TMR_W'(SETTLE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GATE_LOAD   = TMR_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    state_t           state, state_nxt;
    logic [1:0]       ch, ch_nxt;
    logic [TMR_W-1:0] tmr;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] shadow_r, shadow_g, shadow_b;
    logic             sync1, sync2, prev, rise;
    logic             busy_nxt, done_nxt;
    logic             enter_settle, enter_gate, publish, store_en;

    function automatic logic [1:0] filter_code(input logic [1:0] c);
        case (c)
            2'd0:    return 2'b00;
            2'd1:    return 2'b11;
            2'd2:    return 2'b01;
            default: return 2'b10;
        endcase
    endfunction

    // Two flops resolve metastability; the third gives the previous level for edge detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= sensor_out;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign rise = sync2 & ~prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = SETTLE;
            SETTLE: begin
                if (!start)          state_nxt = IDLE;
                else if (tmr == '0)  state_nxt = GATE;
            end
            GATE: begin
                if (!start)          state_nxt = IDLE;
                else if (tmr == '0)  state_nxt = STORE;
            end
            STORE: begin
                if (!start)          state_nxt = IDLE;
                else if (ch == 2'd3) state_nxt = DONE;
                else                 state_nxt = SETTLE;
            end
            DONE:    if (!start) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_nxt     = 1'b0;
        done_nxt     = 1'b0;
        ch_nxt       = ch;
        enter_settle = 1'b0;
        enter_gate   = 1'b0;
        publish      = 1'b0;
        store_en     = 1'b0;
        unique case (state_nxt)
            SETTLE, GATE, STORE: busy_nxt = 1'b1;
            DONE:                done_nxt = 1'b1;
            default:             ;
        endcase
        unique case (state)
            IDLE: begin
                if (state_nxt == SETTLE) begin
                    enter_settle = 1'b1;
                    ch_nxt       = 2'd0;
                end
            end
            SETTLE:  enter_gate = (state_nxt == GATE);
            STORE: begin
                store_en = (state_nxt != IDLE);
                publish  = (state_nxt == DONE);
                if (state_nxt == SETTLE) begin
                    enter_settle = 1'b1;
                    ch_nxt       = ch + 2'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ch         <= 2'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            s2         <= 1'b0;
            s3         <= 1'b0;
            tmr        <= '0;
            cnt        <= '0;
            shadow_r   <= '0;
            shadow_g   <= '0;
            shadow_b   <= '0;
            red_freq   <= '0;
            green_freq <= '0;
            blue_freq  <= '0;
            clear_freq <= '0;
        end else begin
            ch   <= ch_nxt;
            busy <= busy_nxt;
            done <= done_nxt;

            if (enter_settle) begin
                {s2, s3} <= filter_code(ch_nxt);
                tmr      <= SETTLE_LOAD;
            end else if (enter_gate) begin
                tmr <= GATE_LOAD;
            end else if (tmr != '0) begin
                tmr <= tmr - 1'b1;
            end

            // Saturating count; a wrapped count would mislead the downstream divider.
            if (enter_gate)
                cnt <= '0;
            else if (state == GATE && rise && cnt != CNT_MAX)
                cnt <= cnt + 1'b1;

            if (store_en) begin
                case (ch)
                    2'd0:    shadow_r <= cnt;
                    2'd1:    shadow_g <= cnt;
                    2'd2:    shadow_b <= cnt;
                    default: ;
                endcase
            end

            // Clear channel goes straight from the counter so all four land on one edge.
            if (publish) begin
                red_freq   <= shadow_r;
                green_freq <= shadow_g;
                blue_freq  <= shadow_b;
                clear_freq <= cnt;
            end
        end
    end

endmodule
